fetch_queue: RTL and testbench

- Parametrised per-instruction fetch queue between the IF stage and ID.
- Accepts a bundle of up to IN_W instructions per cycle with a contiguous valid mask, and stores each instruction as its own entry.
- Presents the oldest OUT_W entries to decode, which pops 0..OUT_W of them per cycle.
- Adds what the fixed two-wide buffer lacks: partial bundles, partial pops, pipeline flush, occupancy and almost-full outputs.

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 tb/tb_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: per-instruction fetch queue between IF and ID.
//
// IF writes a bundle of up to IN_W instructions per cycle. The valid mask must
// be contiguous from lane 0. Each instruction becomes its own entry in a
// circular buffer. Decode sees the oldest OUT_W entries and pops 0..OUT_W of
// them per cycle, always from the lowest lanes.
//
// Handshake: a bundle is accepted only when in_ready is high, and then all of
// it is accepted; otherwise all of it is dropped and upstream must hold it.
// out_valid[k] is the lane-valid for decode. pop_num says how many of the low
// lanes decode consumed this cycle; any excess over the valid lanes is clipped.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN): when the queue is empty and
// not flushing, the in lanes are forwarded straight to the out lanes. Lanes
// popped in that same cycle are never written to storage.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         drop all contents (beats push and pop)
//   in_valid      IN_W lane-valid mask, contiguous from lane 0
//   in_payload    IN_W x PAYLOAD_W, lane k at [k*PAYLOAD_W +: PAYLOAD_W]
//   in_ready      room for a full IN_W bundle (from registered count only)
//   out_valid     OUT_W lane-valid, lane 0 = oldest entry
//   out_payload   OUT_W x PAYLOAD_W, invalid lanes drive zero
//   pop_num       lanes consumed this cycle
//   count         occupancy; empty / full / almost_full derived from it
module fetch_queue #(
  parameter int IN_W      = 2,
  parameter int OUT_W     = 2,
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 75,
  parameter int AF_THRESH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [IN_W-1:0]                in_valid,
  input  logic [IN_W*PAYLOAD_W-1:0]      in_payload,
  output logic                           in_ready,
  output logic [OUT_W-1:0]               out_valid,
  output logic [OUT_W*PAYLOAD_W-1:0]     out_payload,
  input  logic [$clog2(OUT_W+1)-1:0]     pop_num,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;

  logic [CNT_W-1:0]     push_n, pop_n, pop_req, skip_n, avail_n;
  logic                 bypass;
  logic [IN_W-1:0]      lane_we;
  logic [PTR_W-1:0]     lane_addr [IN_W];

`ifdef FETCH_QUEUE_BYPASS_EN
  // Zero-extended copies so out lanes beyond IN_W read as invalid.
  logic [MAX_W-1:0]           in_valid_x;
  logic [MAX_W*PAYLOAD_W-1:0] in_payload_x;
  assign in_valid_x   = MAX_W'(in_valid);
  assign in_payload_x = (MAX_W*PAYLOAD_W)'(in_payload);
`endif

  // Space freed by a same-cycle pop is deliberately not counted here.
  assign in_ready = !flush && (count_q <= CNT_W'(DEPTH - IN_W));

  always_comb begin
    push_n = '0;
    for (int k = 0; k < IN_W; k++) begin
      push_n = push_n + CNT_W'(in_valid[k]);
    end
    if (!in_ready) begin
      push_n = '0;
    end
  end

  // Read side: avail_n is the number of valid out lanes, used to clip pops.
  always_comb begin
    out_valid   = '0;
    out_payload = '0;
    avail_n     = '0;
    bypass      = 1'b0;
    for (int k = 0; k < OUT_W; k++) begin
      if (!flush && (count_q > CNT_W'(k))) begin
        out_valid[k] = 1'b1;
        out_payload[k*PAYLOAD_W +: PAYLOAD_W] = mem[head_q + PTR_W'(k)];
        avail_n = avail_n + CNT_W'(1);
      end
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!flush && (count_q == '0)) begin
      bypass = 1'b1;
      for (int k = 0; k < OUT_W; k++) begin
        if (in_valid_x[k]) begin
          out_valid[k] = 1'b1;
          out_payload[k*PAYLOAD_W +: PAYLOAD_W] = in_payload_x[k*PAYLOAD_W +: PAYLOAD_W];
          avail_n = avail_n + CNT_W'(1);
        end
      end
    end
`endif
  end

  // In bypass the popped lanes are the lowest pushed lanes, so storage skips
  // them and the head pointer stays put (nothing stored was consumed).
  always_comb begin
    pop_req = CNT_W'(pop_num);
    pop_n   = (pop_req > avail_n) ? avail_n : pop_req;
    skip_n  = bypass ? pop_n : '0;
    for (int k = 0; k < IN_W; k++) begin
      lane_we[k]   = (CNT_W'(k) >= skip_n) && (CNT_W'(k) < push_n) && !rst;
      lane_addr[k] = tail_q + PTR_W'(CNT_W'(k) - skip_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop_n - skip_n);
      tail_q  <= tail_q + PTR_W'(push_n - skip_n);
      count_q <= count_q + push_n - pop_n;
    end
  end

  // Storage has no reset; lane_we is gated by rst so no write lands while
  // reset is asserted.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_W; k++) begin
      if (lane_we[k]) begin
        mem[lane_addr[k]] <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors, hand-written reset sequence and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int DEPTH = 16;
  localparam int PW    = 75;
  localparam int AF    = 12;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int PNW   = $clog2(OUT_W+1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic [IN_W-1:0]     in_valid = '0;
  logic [IN_W*PW-1:0]  in_payload = '0;
  logic                in_ready;
  logic [OUT_W-1:0]    out_valid;
  logic [OUT_W*PW-1:0] out_payload;
  logic [PNW-1:0]      pop_num = '0;
  logic [CW-1:0]       count;
  logic                empty, full, almost_full;

  always #5 clk = ~clk;

  fetch_queue #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .PAYLOAD_W(PW), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_ready(in_ready),
    .out_valid(out_valid), .out_payload(out_payload), .pop_num(pop_num),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] lane_pl[IN_W];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    return {11'($urandom), pc, 32'($urandom)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] v, input logic [1:0] p, input logic f,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    lane_pl[0] = mk(pc0);
    lane_pl[1] = mk(pc1);
    in_valid   = v;
    pop_num    = p;
    flush      = f;
    in_payload = {lane_pl[1], lane_pl[0]};
  endtask

  // Reference model: the queue content after the edge. Accepted lanes are
  // appended in lane order, then the clipped pop count leaves from the front
  // (pops only ever reach entries that were there before the push, or the
  // bypassed lanes when the queue was empty).
  task automatic model_update(input logic [1:0] v, input logic [1:0] p, input logic f);
    int sz, vis, np;
    logic [PW-1:0] pushq[$];
    sz = exp_q.size();
    if (f) begin
      exp_q.delete();
      return;
    end
    if (DEPTH - sz >= IN_W)
      for (int k = 0; k < IN_W; k++) if (v[k]) pushq.push_back(lane_pl[k]);
    if (BYP && sz == 0) vis = (pushq.size() < OUT_W) ? pushq.size() : OUT_W;
    else                vis = (sz < OUT_W) ? sz : OUT_W;
    np = (int'(p) < vis) ? int'(p) : vis;
    foreach (pushq[i]) exp_q.push_back(pushq[i]);
    repeat (np) void'(exp_q.pop_front());
  endtask

  task automatic model_cycle(input logic [1:0] v, input logic [1:0] p, input logic f,
                             input logic [31:0] pc0, input logic [31:0] pc1);
    int sz;
    logic ov;
    logic [PW-1:0] el;
    drive(v, p, f, pc0, pc1);
    #1;
    sz = exp_q.size();
    check("count", PW'(count), PW'(sz));
    check("empty", PW'(empty), PW'(sz == 0));
    check("full", PW'(full), PW'(sz == DEPTH));
    check("almost_full", PW'(almost_full), PW'(sz >= AF));
    check("in_ready", PW'(in_ready), PW'(!f && (DEPTH - sz >= IN_W)));
    for (int k = 0; k < OUT_W; k++) begin
      if (f) begin
        ov = 1'b0; el = '0;
      end else if (BYP && sz == 0) begin
        ov = v[k]; el = v[k] ? lane_pl[k] : '0;
      end else begin
        ov = (sz > k); el = ov ? exp_q[k] : '0;
      end
      check($sformatf("out_valid%0d", k), PW'(out_valid[k]), PW'(ov));
      check($sformatf("out_payload%0d", k), out_payload[k*PW +: PW], el);
    end
    model_update(v, p, f);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  p;
    logic        f;
    logic [31:0] pc0;
    logic [31:0] pc1;
    int          cnt;
    logic        rdy;
    logic        fl;
    logic        af;
    logic [1:0]  ov;
    logic [31:0] epc0;
    logic [31:0] epc1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] v, input logic [1:0] p, input logic f,
                              input logic [31:0] pc0, input logic [31:0] pc1, input int cnt,
                              input logic rdy, input logic fl, input logic af, input logic [1:0] ov,
                              input logic [31:0] epc0, input logic [31:0] epc1);
    vec_t t;
    t.v = v; t.p = p; t.f = f; t.pc0 = pc0; t.pc1 = pc1; t.cnt = cnt;
    t.rdy = rdy; t.fl = fl; t.af = af; t.ov = ov; t.epc0 = epc0; t.epc1 = epc1;
    vecs.push_back(t);
  endfunction

  task automatic run_vec(input int idx, input vec_t t);
    drive(t.v, t.p, t.f, t.pc0, t.pc1);
    #1;
    check($sformatf("v%0d_count", idx), PW'(count), PW'(t.cnt));
    check($sformatf("v%0d_in_ready", idx), PW'(in_ready), PW'(t.rdy));
    check($sformatf("v%0d_full", idx), PW'(full), PW'(t.fl));
    check($sformatf("v%0d_almost_full", idx), PW'(almost_full), PW'(t.af));
    check($sformatf("v%0d_out_valid", idx), PW'(out_valid), PW'(t.ov));
    check($sformatf("v%0d_pc0", idx), PW'(out_payload[32 +: 32]), PW'(t.epc0));
    check($sformatf("v%0d_pc1", idx), PW'(out_payload[PW+32 +: 32]), PW'(t.epc1));
    model_update(t.v, t.p, t.f);
    @(posedge clk);
    #1;
  endtask

  function automatic void build_table();
    logic [31:0] a;
    a = 32'h0000_1000;
    // fill with full bundles, no pops
    for (int i = 0; i < 8; i++)
      add(2'b11, 2'd0, 1'b0, a + 32'(8*i), a + 32'(8*i + 4), 2*i, 1'b1, 1'b0, (2*i >= AF),
          (i == 0 && !BYP) ? 2'b00 : 2'b11, (i == 0 && !BYP) ? 32'h0 : a, (i == 0 && !BYP) ? 32'h0 : a + 4);
    add(2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 16, 1'b0, 1'b1, 1'b1, 2'b11, a, a + 4);
    // full with simultaneous pop: push dropped, pop of 2 taken
    add(2'b11, 2'd2, 1'b0, 32'h1111_0000, 32'h1111_0004, 16, 1'b0, 1'b1, 1'b1, 2'b11, a, a + 4);
    add(2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 14, 1'b1, 1'b0, 1'b1, 2'b11, a + 8, a + 12);
    // flush from 14 together with push and pop
    add(2'b11, 2'd2, 1'b1, 32'h2222_0000, 32'h2222_0004, 14, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    // partial bundle and partial pops
    add(2'b11, 2'd0, 1'b0, 32'h1c00_0000, 32'h1c00_0004, 0, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b11 : 2'b00, BYP ? 32'h1c00_0000 : 32'h0, BYP ? 32'h1c00_0004 : 32'h0);
    add(2'b01, 2'd0, 1'b0, 32'h1c00_0008, 32'h0, 2, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c00_0000, 32'h1c00_0004);
    add(2'b00, 2'd1, 1'b0, 32'h0, 32'h0, 3, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c00_0000, 32'h1c00_0004);
    add(2'b00, 2'd2, 1'b0, 32'h0, 32'h0, 2, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c00_0004, 32'h1c00_0008);
    // clipped pop: pop_num=2 with one entry
    add(2'b01, 2'd0, 1'b0, 32'h0000_2000, 32'h0, 0, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b01 : 2'b00, BYP ? 32'h0000_2000 : 32'h0, 32'h0);
    add(2'b00, 2'd2, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2000, 32'h0);
    // build count 7, then flush with push and pop
    add(2'b11, 2'd0, 1'b0, 32'h3000, 32'h3004, 0, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b11 : 2'b00, BYP ? 32'h3000 : 32'h0, BYP ? 32'h3004 : 32'h0);
    add(2'b11, 2'd0, 1'b0, 32'h3008, 32'h300c, 2, 1'b1, 1'b0, 1'b0, 2'b11, 32'h3000, 32'h3004);
    add(2'b11, 2'd0, 1'b0, 32'h3010, 32'h3014, 4, 1'b1, 1'b0, 1'b0, 2'b11, 32'h3000, 32'h3004);
    add(2'b01, 2'd0, 1'b0, 32'h3018, 32'h0, 6, 1'b1, 1'b0, 1'b0, 2'b11, 32'h3000, 32'h3004);
    add(2'b11, 2'd2, 1'b1, 32'h4444_0000, 32'h4444_0004, 7, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    add(2'b11, 2'd0, 1'b0, 32'h5000, 32'h5004, 0, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b11 : 2'b00, BYP ? 32'h5000 : 32'h0, BYP ? 32'h5004 : 32'h0);
    add(2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 2, 1'b1, 1'b0, 1'b0, 2'b11, 32'h5000, 32'h5004);
    add(2'b00, 2'd2, 1'b0, 32'h0, 32'h0, 2, 1'b1, 1'b0, 1'b0, 2'b11, 32'h5000, 32'h5004);
    // empty-queue latency: bypass forwards in the same cycle, else one cycle later
    add(2'b11, 2'd1, 1'b0, 32'h1c00_0100, 32'h1c00_0104, 0, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b11 : 2'b00, BYP ? 32'h1c00_0100 : 32'h0, BYP ? 32'h1c00_0104 : 32'h0);
    add(2'b00, 2'd0, 1'b0, 32'h0, 32'h0, BYP ? 1 : 2, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b01 : 2'b11, BYP ? 32'h1c00_0104 : 32'h1c00_0100, BYP ? 32'h0 : 32'h1c00_0104);
    add(2'b00, 2'd2, 1'b0, 32'h0, 32'h0, BYP ? 1 : 2, 1'b1, 1'b0, 1'b0,
        BYP ? 2'b01 : 2'b11, BYP ? 32'h1c00_0104 : 32'h1c00_0100, BYP ? 32'h0 : 32'h1c00_0104);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0]  v, p;
    logic        f;
    logic [31:0] pc;
    int          r;
    build_table();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", PW'(count), PW'(0));
    check("rst_empty", PW'(empty), PW'(1));
    check("rst_full", PW'(full), PW'(0));
    check("rst_almost_full", PW'(almost_full), PW'(0));
    check("rst_in_ready", PW'(in_ready), PW'(1));
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_out_payload", out_payload[PW-1:0], '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // randomized traffic against the model, pushes biased to reach full
    pc = 32'h8000_0000;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 3);
      v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      p = 2'($urandom_range(0, 2));
      f = ($urandom_range(0, 29) == 0);
      model_cycle(v, p, f, pc, pc + 4);
      pc = pc + 8;
    end

    // reset in the middle of traffic: clears at once, no write while held
    model_cycle(2'b11, 2'd0, 1'b0, 32'h9000_0000, 32'h9000_0004);
    model_cycle(2'b11, 2'd0, 1'b0, 32'h9000_0008, 32'h9000_000c);
    drive(2'b11, 2'd0, 1'b0, 32'h9100_0000, 32'h9100_0004);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", PW'(count), PW'(0));
    check("async_rst_empty", PW'(empty), PW'(1));
    @(posedge clk);
    #1;
    check("held_rst_count", PW'(count), PW'(0));
    rst = 1'b0;
    exp_q.delete();
    drive(2'b00, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    check("post_rst_out_valid", PW'(out_valid), PW'(0));
    @(posedge clk);
    #1;
    model_cycle(2'b11, 2'd0, 1'b0, 32'h9200_0000, 32'h9200_0004);
    model_cycle(2'b00, 2'd1, 1'b0, 32'h0, 32'h0);
    model_cycle(2'b00, 2'd2, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
